// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings and FSM state type for the pipeline hazard unit.
package hazard_pkg;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W = 2'b01;
    localparam logic [1:0] FWD_M = 2'b10;
    localparam logic [1:0] RES_SRC_MEM = 2'b01;
    typedef enum logic [1:0] {IDLE, LU_WAIT, MD_BUSY} hz_state_t;
endpackage

// File: rtl/hazard_unit_mc_if.sv
// hazard_unit_mc_if: datapath <-> hazard unit bundle; master is the datapath, slave the hazard unit.
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W = 16
);
    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic PCSrcE, MdStartE, MdDoneE;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [CNT_W-1:0] StallCnt, FlushCnt;
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, MdStartE, MdDoneE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
               StallCnt, FlushCnt
    );
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
               ResultSrcE, PCSrcE, MdStartE, MdDoneE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
               StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: forwarding select for one Execute operand; M beats W, x0 never forwards.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regWriteM,
    input  logic              regWriteW,
    output logic [1:0]        forward
);
    always_comb
        forward = (regWriteM && rdM != '0 && rsE == rdM) ? FWD_M :
                  (regWriteW && rdW != '0 && rsE == rdW) ? FWD_W : FWD_RF;
endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use and MUL/DIV stalls, branch flush and saturating perf counters.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_mc_if.slave hz
);
    localparam logic [1:0] LU_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;
    hz_state_t state;
    logic [1:0] luCnt;
    logic [CNT_W-1:0] stallCnt, flushCnt;
    logic lu, luIdle, luStall, mdIdle, mdStall;
    hazard_fwd_sel #(.REG_AW(REG_AW)) fwdA (
        .rsE(hz.Rs1E), .rdM(hz.RdM), .rdW(hz.RdW),
        .regWriteM(hz.RegWriteM), .regWriteW(hz.RegWriteW), .forward(hz.ForwardAE)
    );
    hazard_fwd_sel #(.REG_AW(REG_AW)) fwdB (
        .rsE(hz.Rs2E), .rdM(hz.RdM), .rdW(hz.RdW),
        .regWriteM(hz.RegWriteM), .regWriteW(hz.RegWriteW), .forward(hz.ForwardBE)
    );
    // A taken branch squashes the load-use victim in D, so it suppresses the stall.
    always_comb begin
        lu = hz.ResultSrcE == RES_SRC_MEM && hz.RdE != '0 &&
             (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
        luIdle = state == IDLE && lu && !hz.PCSrcE;
        luStall = luIdle || state == LU_WAIT;
        mdIdle = state == IDLE && hz.MdStartE && !hz.MdDoneE;
        mdStall = mdIdle || (state == MD_BUSY && !hz.MdDoneE);
    end
    assign hz.StallF = luStall || mdStall;
    assign hz.StallD = luStall || mdStall;
    assign hz.StallE = mdStall;
    assign hz.FlushM = mdStall;
    assign hz.FlushD = hz.PCSrcE;
    assign hz.FlushE = hz.PCSrcE || luStall;
    assign hz.StallCnt = stallCnt;
    assign hz.FlushCnt = flushCnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            luCnt <= '0;
        end else begin
            case (state)
                IDLE:
                    if (mdIdle) state <= MD_BUSY;
                    else if (luIdle && LOAD_STALL > 1) begin
                        luCnt <= LU_INIT;
                        state <= LU_WAIT;
                    end
                LU_WAIT:
                    if (luCnt == 2'd0) state <= IDLE;
                    else luCnt <= luCnt - 2'd1;
                MD_BUSY:
                    if (hz.MdDoneE) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (hz.StallF && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
            if (hz.PCSrcE && flushCnt != '1) flushCnt <= flushCnt + 1'b1;
        end
    end
endmodule
